// File: rtl/tdm_8to1_serializer.sv
// Time-division 8-to-1 serializer: accepts an 8-word frame in one handshake and
// emits one word per accepted beat with its channel index for a downstream demux.
module tdm_8to1_serializer #(
    parameter int W = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] x7_x0,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   z0,
    output logic [2:0]     b2_b0,
    output logic           sof
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [2:0]     r_idx;
    logic [2:0]     w_idxNext;
    logic [8*W-1:0] r_frame;
    logic [8*W-1:0] w_frameNext;
    logic           w_sending;
    logic           w_lastBeat;
    logic           w_inFire;
    logic           w_outFire;

    assign w_sending  = (r_state == S_SEND);
    assign w_lastBeat = (r_idx == 3'd7);

    // Accepting on the last beat lets the next frame follow with no idle bubble.
    assign in_ready  = !reset && ((r_state == S_IDLE) || (w_sending && w_lastBeat && out_ready));
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = w_sending && out_ready;

    assign out_valid = w_sending;
    assign b2_b0     = w_sending ? r_idx : 3'd0;
    assign sof       = w_sending && (r_idx == 3'd0);
    assign z0        = w_sending ? r_frame[r_idx*W +: W] : '0;

    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_frameNext = r_frame;
        case (r_state)
            S_IDLE: begin
                w_idxNext = 3'd0;
            end
            S_SEND: begin
                if (w_outFire) begin
                    if (w_lastBeat) begin
                        w_idxNext   = 3'd0;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_idxNext = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_idxNext   = 3'd0;
            end
        endcase
        if (w_inFire) begin
            w_frameNext = x7_x0;
            w_idxNext   = 3'd0;
            w_stateNext = S_SEND;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_frame <= '0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            r_frame <= w_frameNext;
        end
    end

endmodule

// File: tb/tb_tdm_8to1_serializer.sv
// Directed bench for tdm_8to1_serializer: a W=1 instance for the framing/handshake
// cases and a W=4 instance looped back into a behavioural 1-to-8 demux bank.
module tb_tdm_8to1_serializer;

    logic        clock = 1'b0;
    logic        reset;

    logic        inValid;
    logic        inReady;
    logic [7:0]  frameIn;
    logic        outValid;
    logic        outReady;
    logic [0:0]  z1;
    logic [2:0]  b1;
    logic        sof1;

    logic        inValid4;
    logic        inReady4;
    logic [31:0] frame4;
    logic        outValid4;
    logic        outReady4;
    logic [3:0]  z4;
    logic [2:0]  b4;
    logic        sof4;

    int          checkCount = 0;
    int          passCount  = 0;

    always #5 clock = ~clock;

    tdm_8to1_serializer #(.W(1)) dut1 (
        .clock(clock), .reset(reset),
        .in_valid(inValid), .in_ready(inReady), .x7_x0(frameIn),
        .out_valid(outValid), .out_ready(outReady),
        .z0(z1), .b2_b0(b1), .sof(sof1)
    );

    tdm_8to1_serializer #(.W(4)) dut4 (
        .clock(clock), .reset(reset),
        .in_valid(inValid4), .in_ready(inReady4), .x7_x0(frame4),
        .out_valid(outValid4), .out_ready(outReady4),
        .z0(z4), .b2_b0(b4), .sof(sof4)
    );

    // Drives the W=1 instance's inputs in one step.
    task automatic applyStimulus(input logic v, input logic r, input logic [7:0] f);
        inValid  = v;
        outReady = r;
        frameIn  = f;
    endtask

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    initial begin
        logic [7:0]  expSingle;
        logic [7:0]  frameA;
        logic [7:0]  frameB;
        logic [7:0]  frameBp;
        logic [7:0]  frameBusy;
        logic [3:0]  bpPat;
        logic [31:0] bank;
        int          fires;

        expSingle = 8'b1011_0010;
        frameA    = 8'hA5;
        frameB    = 8'h3C;
        frameBp   = 8'hF0;
        frameBusy = 8'h5A;
        bpPat     = 4'b1001;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        inValid4 = 1'b0; outReady4 = 1'b0; frame4 = 32'h0;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rst_in_ready", 32'(inReady), 32'd0);
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_out_valid4", 32'(outValid4), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("idle_in_ready", 32'(inReady), 32'd1);
        checkOutput("idle_sof", 32'(sof1), 32'd0);

        // Single frame 8'b1011_0010: z0 = 0,1,0,0,1,1,0,1.
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, expSingle);
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("t2_valid_%0d", k), 32'(outValid), 32'd1);
            checkOutput($sformatf("t2_b_%0d", k), 32'(b1), 32'(k));
            checkOutput($sformatf("t2_z_%0d", k), 32'(z1), 32'(expSingle[k]));
            checkOutput($sformatf("t2_sof_%0d", k), 32'(sof1), (k == 0) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        #1;
        checkOutput("t2_done_valid", 32'(outValid), 32'd0);
        checkOutput("t2_done_ready", 32'(inReady), 32'd1);

        // Back-to-back frames A5 then 3C with in_valid held high.
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, frameA);
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, frameB);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) applyStimulus(1'b0, 1'b1, frameB);
            #1;
            checkOutput($sformatf("t3_valid_%0d", k), 32'(outValid), 32'd1);
            checkOutput($sformatf("t3_b_%0d", k), 32'(b1), 32'(k % 8));
            checkOutput($sformatf("t3_z_%0d", k), 32'(z1),
                        (k < 8) ? 32'(frameA[k % 8]) : 32'(frameB[k % 8]));
            checkOutput($sformatf("t3_sof_%0d", k), 32'(sof1), (k % 8 == 0) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t3_in_ready_%0d", k), 32'(inReady), (k % 8 == 7) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        #1;
        checkOutput("t3_done_valid", 32'(outValid), 32'd0);

        // Backpressure on frame F0, out_ready pattern 1,0,0,1 repeating.
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, frameBp);
        @(negedge clock);
        fires = 0;
        for (int c = 0; c < 40 && fires < 8; c++) begin
            applyStimulus(1'b0, bpPat[c % 4], frameBp);
            #1;
            checkOutput($sformatf("t4_valid_%0d", c), 32'(outValid), 32'd1);
            checkOutput($sformatf("t4_b_%0d", c), 32'(b1), 32'(fires));
            checkOutput($sformatf("t4_z_%0d", c), 32'(z1), 32'(frameBp[fires[2:0]]));
            checkOutput($sformatf("t4_sof_%0d", c), 32'(sof1), (fires == 0) ? 32'd1 : 32'd0);
            if (outReady) fires++;
            @(negedge clock);
        end
        checkOutput("t4_fires", 32'(fires), 32'd8);
        #1;
        checkOutput("t4_done_valid", 32'(outValid), 32'd0);

        // Input offered while busy must be refused and must not disturb the frame.
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, frameBusy);
        @(negedge clock);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("t5_in_ready_%0d", c), 32'(inReady), 32'd0);
            checkOutput($sformatf("t5_z_%0d", c), 32'(z1), 32'(frameBusy[0]));
            checkOutput($sformatf("t5_b_%0d", c), 32'(b1), 32'd0);
            @(negedge clock);
        end
        applyStimulus(1'b1, 1'b1, 8'h00);
        #1;
        checkOutput("t5_in_ready_fire", 32'(inReady), 32'd0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 8'h00);
        for (int k = 1; k < 8; k++) begin
            #1;
            checkOutput($sformatf("t5_drain_b_%0d", k), 32'(b1), 32'(k));
            checkOutput($sformatf("t5_drain_z_%0d", k), 32'(z1), 32'(frameBusy[k]));
            @(negedge clock);
        end
        #1;
        checkOutput("t5_done_valid", 32'(outValid), 32'd0);

        // Asynchronous reset in the middle of a frame at idx 3.
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 8'hC3);
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 8'h00);
        repeat (3) @(negedge clock);
        #1;
        checkOutput("t1_pre_b", 32'(b1), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t1_async_valid", 32'(outValid), 32'd0);
        checkOutput("t1_async_ready", 32'(inReady), 32'd0);
        checkOutput("t1_async_b", 32'(b1), 32'd0);
        checkOutput("t1_async_z", 32'(z1), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("t1_post_ready", 32'(inReady), 32'd1);
        checkOutput("t1_post_valid", 32'(outValid), 32'd0);
        @(negedge clock);
        #1;
        checkOutput("t1_post_valid2", 32'(outValid), 32'd0);

        // W=4 loopback through a behavioural demux into a register bank.
        @(negedge clock);
        inValid4 = 1'b1; outReady4 = 1'b1; frame4 = 32'h7654_3210;
        @(negedge clock);
        inValid4 = 1'b0; frame4 = 32'hFFFF_FFFF;
        bank  = 32'h0;
        fires = 0;
        for (int c = 0; c < 20 && fires < 8; c++) begin
            #1;
            if (fires == 0) checkOutput("t6_sof", 32'(sof4), 32'd1);
            if (outValid4 && outReady4) begin
                bank[b4*4 +: 4] = z4;
                fires++;
            end
            @(negedge clock);
        end
        checkOutput("t6_fires", 32'(fires), 32'd8);
        checkOutput("t6_bank", bank, 32'h7654_3210);
        #1;
        checkOutput("t6_done_valid", 32'(outValid4), 32'd0);
        checkOutput("t6_done_ready", 32'(inReady4), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
